mux4_rr_merge: RTL and testbench
================================

# mux4_rr_merge

- Merges four independent valid/ready input lanes into one registered output stream using round-robin arbitration.
- Tags every output beat with the 2-bit index of its source lane, so a downstream `Demux1to4`-style stage can route it back out.
- Sits upstream of the lane demultiplexer and performs the collecting (4-to-1) direction of the same lane interface.

## Interface
Parameters:
- WIDTH, 8, data width of every lane and of the output

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-high reset
- In_Valid  input  4  per-lane beat valid; bit i belongs to lane i
- In_Data0 .. In_Data3  input  WIDTH  lane 0..3 payload
- In_Last  input  4  per-lane end-of-packet flag, qualified by In_Valid
- In_Ready  output  4  per-lane accept; a beat transfers on lane i when In_Valid[i] && In_Ready[i]
- Y_Valid  output  1  output beat valid
- Y_Data  output  WIDTH  output payload
- Y_Last  output  1  copy of In_Last of the accepted beat
- Y_Sel  output  2  source lane index of the current output beat
- Y_Ready  input  1  downstream accept; output transfers on Y_Valid && Y_Ready

## Operation
- Single output register: Y_Valid, Y_Data, Y_Last, Y_Sel.
- Load enable: load = !Y_Valid || Y_Ready. The register may refill in the same cycle it drains.
- Round-robin pointer Ptr[1:0] gives the search order Ptr, Ptr+1, Ptr+2, Ptr+3 (mod 4).
- Grant g is the first lane in that order with In_Valid set.
- In_Ready is combinational: In_Ready[g] = load. All other In_Ready bits are 0. In_Ready is all zero when no lane is valid or load=0.
- On a grant, the register captures In_Data_g, In_Last[g] and g; Y_Valid is set; Ptr becomes g+1 (3 wraps to 0).
- If load=1 and no lane is valid, Y_Valid clears and Y_Data/Y_Last/Y_Sel hold their values.
- Y_Data/Y_Last/Y_Sel are stable while Y_Valid && !Y_Ready.
- Lanes that are not granted see no side effects and keep their beats pending.
- Arbitration is independent of In_Data values.

## Timing
- Reset (async assert, sync release): Y_Valid=0, Y_Data=0, Y_Last=0, Y_Sel=0, Ptr=0, lock cleared. In_Ready is all 0 while Rst=1.
- Latency: an input beat accepted at edge N appears with Y_Valid=1 after edge N.
- Throughput: 1 beat/cycle while Y_Ready=1.
- Backpressure: when Y_Valid=1 and Y_Ready=0, In_Ready is all 0. No input beat is accepted or lost.
- Simultaneous drain and refill: Y_Valid stays 1 with no bubble.
- Reset mid-stream: the register content is discarded and Ptr returns to 0. Input beats not yet accepted remain the upstream's responsibility.

## Configuration
- MUX4_LOCK_EN defined: packet lock.
  - A grant whose In_Last[g]=0 locks arbitration to lane g.
  - While locked, only lane g is eligible. If In_Valid[g]=0, no other lane is served and Y_Valid clears once drained.
  - A granted beat with In_Last[g]=1 releases the lock.
  - Ptr updates to g+1 only on the releasing beat; it is unchanged during the locked beats.
- MUX4_LOCK_EN undefined:
  - Arbitration is per beat.
  - In_Last only propagates to Y_Last.
  - No lock state is synthesized.

## Test plan
- Reset: assert Rst mid-transfer with Y_Valid=1 -> Y_Valid=0, Y_Sel=0, Y_Data=0 immediately, In_Ready=4'b0000. Then, after release, with In_Valid=4'b0100 -> the first beat comes from lane 2.
- Fairness: all lanes valid continuously, Y_Ready=1, In_DataI=8'hA0+i -> Y_Sel sequence 0,1,2,3,0,... and Y_Data A0,A1,A2,A3,A0, one beat per cycle.
- Wrap/skip: Ptr=3, In_Valid=4'b0011 -> grant lane 0, then lane 1. With In_Valid=4'b1000 only -> lane 3 is granted regardless of Ptr.
- Backpressure: hold Y_Ready=0 for 5 cycles with lanes valid -> In_Ready=4'b0000 and Y_Data stable. Then Y_Ready=1 -> no beat lost or duplicated, checked against a scoreboard.
- Idle: In_Valid=4'b0000, Y_Ready=1 -> Y_Valid=0 one cycle after the last beat drains; Y_Sel holds.
- Lock (MUX4_LOCK_EN): lane 1 sends 3 beats (In_Last=0,0,1) while lane 2 is valid -> Y_Sel=1,1,1, then 2. Without the macro, the same stimulus -> Y_Sel=1,2,1,2,1.

Source files
------------

// File: rtl/mux4_rr_merge.sv
// mux4_rr_merge: round-robin merge of four valid/ready lanes into one registered, lane-tagged stream.
// Build option: define MUX4_LOCK_EN to hold arbitration on one lane until its In_Last beat.
module mux4_rr_merge #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [3:0]       In_Valid,
   input  logic [WIDTH-1:0] In_Data0,
   input  logic [WIDTH-1:0] In_Data1,
   input  logic [WIDTH-1:0] In_Data2,
   input  logic [WIDTH-1:0] In_Data3,
   input  logic [3:0]       In_Last,
   output logic [3:0]       In_Ready,
   output logic             Y_Valid,
   output logic [WIDTH-1:0] Y_Data,
   output logic             Y_Last,
   output logic [1:0]       Y_Sel,
   input  logic             Y_Ready
);

   logic [1:0]       ptr;
   logic [3:0]       elig;
   logic [7:0]       dbl;
   logic [3:0]       rot;
   logic [1:0]       off;
   logic [1:0]       gnt;
   logic             gnt_vld;
   logic             load;
   logic             take;
   logic [WIDTH-1:0] gnt_data;

`ifdef MUX4_LOCK_EN
   logic       locked;
   logic [1:0] lock_lane;

   always_comb begin
      elig = In_Valid;
      if (locked)
         elig = In_Valid & (4'b0001 << lock_lane);
   end
`else
   assign elig = In_Valid;
`endif

   // Rotate so bit 0 is the lane at ptr; the lowest set bit wins.
   assign dbl = {elig, elig};
   assign rot = dbl[ptr +: 4];

   always_comb begin
      off = 2'd0;
      priority case (1'b1)
         rot[0]:  off = 2'd0;
         rot[1]:  off = 2'd1;
         rot[2]:  off = 2'd2;
         rot[3]:  off = 2'd3;
         default: off = 2'd0;
      endcase
   end

   assign gnt     = ptr + off;
   assign gnt_vld = |elig;
   assign load    = !Y_Valid || Y_Ready;
   assign take    = load && gnt_vld;

   always_comb begin
      In_Ready = 4'b0000;
      if (take && !Rst)
         In_Ready = 4'b0001 << gnt;
   end

   always_comb begin
      gnt_data = In_Data0;
      unique case (gnt)
         2'd0: gnt_data = In_Data0;
         2'd1: gnt_data = In_Data1;
         2'd2: gnt_data = In_Data2;
         2'd3: gnt_data = In_Data3;
         default: gnt_data = In_Data0;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Y_Valid <= 1'b0;
         Y_Data  <= '0;
         Y_Last  <= 1'b0;
         Y_Sel   <= 2'd0;
      end else if (load) begin
         if (gnt_vld) begin
            Y_Valid <= 1'b1;
            Y_Data  <= gnt_data;
            Y_Last  <= In_Last[gnt];
            Y_Sel   <= gnt;
         end else begin
            Y_Valid <= 1'b0;
         end
      end
   end

`ifdef MUX4_LOCK_EN
   // The pointer only advances when a packet completes.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ptr       <= 2'd0;
         locked    <= 1'b0;
         lock_lane <= 2'd0;
      end else if (take) begin
         if (In_Last[gnt]) begin
            ptr    <= gnt + 2'd1;
            locked <= 1'b0;
         end else begin
            locked    <= 1'b1;
            lock_lane <= gnt;
         end
      end
   end
`else
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         ptr <= 2'd0;
      else if (take)
         ptr <= gnt + 2'd1;
   end
`endif

endmodule

// File: tb/tb_mux4_rr_merge.sv
// Bench for mux4_rr_merge: vector table, reset and packet sequences, scoreboard.
// Honours MUX4_LOCK_EN for the packet-lock expectations.
module tb_mux4_rr_merge;

   localparam int W = 8;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic [3:0]   In_Valid = 4'b0;
   logic [3:0]   In_Last = 4'b0;
   logic [W-1:0] drv_d [4];
   logic [W-1:0] In_Data0, In_Data1, In_Data2, In_Data3;
   logic [3:0]   In_Ready;
   logic         Y_Valid;
   logic [W-1:0] Y_Data;
   logic         Y_Last;
   logic [1:0]   Y_Sel;
   logic         Y_Ready = 1'b0;

   assign In_Data0 = drv_d[0];
   assign In_Data1 = drv_d[1];
   assign In_Data2 = drv_d[2];
   assign In_Data3 = drv_d[3];

   mux4_rr_merge #(.WIDTH(W)) dut (
      .Clk(Clk), .Rst(Rst),
      .In_Valid(In_Valid),
      .In_Data0(In_Data0), .In_Data1(In_Data1),
      .In_Data2(In_Data2), .In_Data3(In_Data3),
      .In_Last(In_Last), .In_Ready(In_Ready),
      .Y_Valid(Y_Valid), .Y_Data(Y_Data),
      .Y_Last(Y_Last), .Y_Sel(Y_Sel),
      .Y_Ready(Y_Ready)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
      logic [1:0]   sel;
   } beat_t;

   typedef struct {
      logic [3:0] iv;
      logic       yr;
      logic [3:0] er;
      logic       yv;
      logic [1:0] sel;
   } vec_t;

   int checks = 0;
   int failures = 0;

   beat_t      sb[$];
   logic [1:0] obs_sel[$];
   logic [W:0] lane_mem [4][16];
   int         hd[4];
   int         tl[4];
   logic       use_q = 1'b0;

   logic [1:0] m_ptr = 2'd0;
   logic       m_yv = 1'b0;
   logic       m_lock = 1'b0;
   logic [1:0] m_lane = 2'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 2'd0;
      m_yv = 1'b0;
      m_lock = 1'b0;
      m_lane = 2'd0;
      sb.delete();
   endtask

   task automatic drive(input logic yr, input logic [3:0] dv);
      logic [3:0] v;
      logic [3:0] l;
      for (int i = 0; i < 4; i++) begin
         if (use_q) begin
            v[i] = (hd[i] != tl[i]);
            drv_d[i] = v[i] ? lane_mem[i][hd[i]][W-1:0] : '0;
            l[i] = v[i] && lane_mem[i][hd[i]][W];
         end else begin
            v[i] = dv[i];
            drv_d[i] = 8'(160 + i);
            l[i] = 1'b1;
         end
      end
      In_Valid = v;
      In_Last = l;
      Y_Ready = yr;
   endtask

   // Reference check and update; called at the falling edge with inputs stable.
   task automatic step();
      int         g;
      logic       load;
      logic [3:0] er;
      beat_t      b;
      beat_t      e;
      load = !m_yv || Y_Ready;
      g = -1;
      for (int k = 0; k < 4; k++) begin
         int l;
         l = (int'(m_ptr) + k) % 4;
         if (g < 0 && In_Valid[l] && (!m_lock || 2'(l) == m_lane))
            g = l;
      end
      er = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
      chk("in_ready", 32'(In_Ready), 32'(er));
      chk("y_valid", 32'(Y_Valid), 32'(m_yv));
      if (Y_Valid && Y_Ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=beat required=none");
         end else begin
            e = sb.pop_front();
            chk("sb_data", 32'(Y_Data), 32'(e.data));
            chk("sb_last", 32'(Y_Last), 32'(e.last));
            chk("sb_sel", 32'(Y_Sel), 32'(e.sel));
            obs_sel.push_back(Y_Sel);
         end
      end
      if (load) begin
         if (g >= 0) begin
            b.data = drv_d[g];
            b.last = In_Last[g];
            b.sel = 2'(g);
            sb.push_back(b);
            m_yv = 1'b1;
`ifdef MUX4_LOCK_EN
            if (b.last) begin
               m_lock = 1'b0;
               m_ptr = 2'(g + 1);
            end else begin
               m_lock = 1'b1;
               m_lane = 2'(g);
            end
`else
            m_ptr = 2'(g + 1);
`endif
            if (use_q)
               hd[g]++;
         end else begin
            m_yv = 1'b0;
         end
      end
   endtask

   task automatic cycle(input logic yr, input logic [3:0] dv);
      drive(yr, dv);
      @(negedge Clk);
      step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      model_reset();
      @(posedge Clk);
      #1;
      Rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t       vt[22];
      logic [1:0] exp_lock[6];

      vt[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
      vt[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
      vt[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
      vt[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
      vt[4]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd3};
      vt[5]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd2};
      vt[6]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd0};
      vt[7]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd1};
      vt[8]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
      vt[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
      vt[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
      vt[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
      vt[12] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
      vt[13] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
      vt[14] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
      vt[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
      vt[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
      vt[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
      vt[18] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0};
      vt[19] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1};
      vt[20] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
      vt[21] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};

`ifdef MUX4_LOCK_EN
      exp_lock = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
`else
      exp_lock = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
`endif

      // Reset state with all lanes requesting.
      drive(1'b1, 4'b1111);
      #12;
      chk("rst_y_valid", 32'(Y_Valid), 32'd0);
      chk("rst_y_data", 32'(Y_Data), 32'd0);
      chk("rst_y_last", 32'(Y_Last), 32'd0);
      chk("rst_y_sel", 32'(Y_Sel), 32'd0);
      chk("rst_in_ready", 32'(In_Ready), 32'd0);
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      model_reset();

      for (int r = 0; r < 22; r++) begin
         drive(vt[r].yr, vt[r].iv);
         @(negedge Clk);
         chk($sformatf("tv%0d_ready", r), 32'(In_Ready), 32'(vt[r].er));
         chk($sformatf("tv%0d_valid", r), 32'(Y_Valid), 32'(vt[r].yv));
         chk($sformatf("tv%0d_sel", r), 32'(Y_Sel), 32'(vt[r].sel));
         if (vt[r].yv)
            chk($sformatf("tv%0d_data", r), 32'(Y_Data), 32'(8'hA0) + 32'(vt[r].sel));
         step();
         @(posedge Clk);
         #1;
      end

      // Reset while a lane-3 beat is held under backpressure.
      cycle(1'b0, 4'b1000);
      cycle(1'b0, 4'b1000);
      drive(1'b0, 4'b1000);
      #2;
      Rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(Y_Valid), 32'd0);
      chk("mid_rst_sel", 32'(Y_Sel), 32'd0);
      chk("mid_rst_data", 32'(Y_Data), 32'd0);
      chk("mid_rst_ready", 32'(In_Ready), 32'd0);
      model_reset();
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      cycle(1'b1, 4'b0100);
      drive(1'b1, 4'b0000);
      @(negedge Clk);
      chk("post_rst_valid", 32'(Y_Valid), 32'd1);
      chk("post_rst_sel", 32'(Y_Sel), 32'd2);
      step();
      @(posedge Clk);
      #1;

      // Lane 1 sends a 3-beat packet while lane 2 keeps requesting.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
      lane_mem[1][0] = {1'b0, 8'h11};
      lane_mem[1][1] = {1'b0, 8'h12};
      lane_mem[1][2] = {1'b1, 8'h13};
      tl[1] = 3;
      lane_mem[2][0] = {1'b1, 8'h21};
      lane_mem[2][1] = {1'b1, 8'h22};
      lane_mem[2][2] = {1'b1, 8'h23};
      tl[2] = 3;
      use_q = 1'b1;
      obs_sel.delete();
      for (int c = 0; c < 10; c++)
         cycle(1'b1, 4'b0000);
      use_q = 1'b0;
      chk("lock_count", 32'(obs_sel.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < obs_sel.size())
            chk($sformatf("lock_sel%0d", i), 32'(obs_sel[i]), 32'(exp_lock[i]));
      end
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
